bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 175 +++++++++++++++++
 tb/tb_bcd_to_bin.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Multicycle packed-BCD to binary converter (reverse double-dabble).
// One result bit is shifted into the binary field per cycle; done pulses once per conversion.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when any packed digit lies outside 0..9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // One iteration: shift {bcd, bin} right, then pull every digit >= 8 back by 3.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = {1'b0, w[WORK_W-1:1]};
        for (int i = 0; i < DIGITS; i++) begin
            if (s[BIN_W + 4*i +: 4] >= 4'd8) begin
                s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
            end else begin
                s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4];
            end
        end
        return s;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [WORK_W-1:0]   work_r;
    logic [WORK_W-1:0]   step_s;
    logic                bad_r;
    logic                last_iter_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                busy_r;
    logic                done_r;
    logic [BIN_W-1:0]    bin_r;
    logic                err_r;

    assign step_s      = dabble_step(work_r);
    assign last_iter_s = (state_r == SHIFT) && (cnt_r == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode, registered below so busy/done come straight from flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            SHIFT:   busy_nxt_s = 1'b1;
            IDLE:    busy_nxt_s = 1'b0;
            default: busy_nxt_s = 1'b0;
        endcase
        if (last_iter_s) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // Status output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Datapath: load on accept, iterate while shifting, publish result on the last iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            work_r <= {WORK_W{1'b0}};
            bad_r  <= 1'b0;
            bin_r  <= {BIN_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        work_r <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_r  <= {CNT_W{1'b0}};
                        bad_r  <= has_bad_digit(bcd_in);
                    end else begin
                        work_r <= work_r;
                        cnt_r  <= cnt_r;
                        bad_r  <= bad_r;
                    end
                end
                SHIFT: begin
                    work_r <= step_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        bin_r <= bad_r ? {BIN_W{1'b0}} : step_s[BIN_W-1:0];
                        err_r <= bad_r;
                    end else begin
                        bin_r <= bin_r;
                        err_r <= err_r;
                    end
                end
                default: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    work_r <= {WORK_W{1'b0}};
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_r;
    assign err     = err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, multi-cycle corner sequences and a 000-999 sweep.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          exp_bin;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full conversion with latency, busy, result and done-width checks.
    task automatic convert(input logic [11:0] b, input int exp_bin, input logic exp_err);
        int n;
        int busy_bad;
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = ~b;
        n = 0;
        busy_bad = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (busy !== 1'b1) busy_bad++;
        end
        chk("latency", 32'(n), 32'd11);
        chk("busy_during", 32'(busy_bad), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("bin_out", 32'(bin_out), 32'(exp_bin));
        chk("err", 32'(err), 32'(exp_err));
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("bin_hold", 32'(bin_out), 32'(exp_bin));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   ndone;
        int   first_n;
        int   second_n;

        tbl[0]  = '{12'h999, 999, 1'b0};
        tbl[1]  = '{12'h000, 0,   1'b0};
        tbl[2]  = '{12'h250, 250, 1'b0};
        tbl[3]  = '{12'h001, 1,   1'b0};
        tbl[4]  = '{12'h1A5, 0,   1'b1};
        tbl[5]  = '{12'h909, 909, 1'b0};
        tbl[6]  = '{12'h512, 512, 1'b0};
        tbl[7]  = '{12'h099, 99,  1'b0};
        tbl[8]  = '{12'hF00, 0,   1'b1};
        tbl[9]  = '{12'h640, 640, 1'b0};
        tbl[10] = '{12'h00B, 0,   1'b1};
        tbl[11] = '{12'h808, 808, 1'b0};

        // Reset, with start asserted to show reset wins.
        rst    = 1'b1;
        start  = 1'b1;
        bcd_in = 12'h999;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            convert(tbl[i].bcd, tbl[i].exp_bin, tbl[i].exp_err);
        end

        // Start while shifting is ignored; held start is taken in the done cycle.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h123;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'h000;
        ndone = 0;
        first_n = 0;
        second_n = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 4) begin
                start  = 1'b1;
                bcd_in = 12'h456;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_n = n;
                    chk("b2b_first_bin", 32'(bin_out), 32'd123);
                end else begin
                    second_n = n;
                    chk("b2b_second_bin", 32'(bin_out), 32'd456);
                end
            end
            if (n == 12) begin
                chk("b2b_accept_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
        end
        chk("b2b_first_at", 32'(first_n), 32'd11);
        chk("b2b_second_at", 32'(second_n), 32'd22);
        chk("b2b_done_count", 32'(ndone), 32'd2);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bin", 32'(bin_out), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        convert(12'h042, 42, 1'b0);

        // Exhaustive sweep against the decimal value of the loop index.
        for (int i = 0; i < 1000; i++) begin
            logic [11:0] b;
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            convert(b, i, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
